alu_pipe: RTL



---
 rtl/alu_pipe.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready handshake, flags and an internal accumulator.
// Define ALU_SAT_EN to make ADD/SUB/ACC saturate to the signed limits on overflow.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_ACC = 3'b110,
    OP_CLR = 3'b111
  } op_e;

  localparam int MSB = WIDTH - 1;

  op_e              op_dec;
  logic             accept;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] arith_res;

  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;
  logic             nxt_ovf;

  assign op_dec   = op_e'(op);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // One shared adder: SUB and SLT use a + ~b + 1, ACC uses acc + a.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    add_x   = a;
    add_y   = b;
    add_cin = 1'b0;
    case (op_dec)
      OP_SUB, OP_SLT: begin
        add_y   = ~b;
        add_cin = 1'b1;
      end
      OP_ACC: begin
        add_x = acc;
        add_y = a;
      end
      default: ;
    endcase
  end

  assign sum_full = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign sum      = sum_full[MSB:0];
  assign sum_ovf  = (add_x[MSB] == add_y[MSB]) && (sum[MSB] != add_x[MSB]);

`ifdef ALU_SAT_EN
  // On overflow both addends share a sign, which is the sign of the true result.
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  assign arith_res = sum_ovf ? (add_x[MSB] ? SAT_MIN : SAT_MAX) : sum;
`else
  assign arith_res = sum;
`endif

  always_comb begin
    nxt_result = '0;
    nxt_carry  = 1'b0;
    nxt_ovf    = 1'b0;
    case (op_dec)
      OP_ADD, OP_SUB, OP_ACC: begin
        nxt_result = arith_res;
        nxt_carry  = sum_full[WIDTH];
        nxt_ovf    = sum_ovf;
      end
      OP_AND: nxt_result = a & b;
      OP_OR:  nxt_result = a | b;
      OP_XOR: nxt_result = a ^ b;
      OP_SLT: nxt_result = {{(WIDTH-1){1'b0}}, sum[MSB] ^ sum_ovf};
      OP_CLR: nxt_result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= nxt_result;
      carry     <= nxt_carry;
      overflow  <= nxt_ovf;
      zero      <= (nxt_result == '0);
      negative  <= nxt_result[MSB];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // CLR's next result is zero and ACC's is the new sum, so both load nxt_result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept && (op_dec == OP_ACC || op_dec == OP_CLR)) begin
      acc <= nxt_result;
    end
  end

endmodule
